// File: rtl/led_pulse_driver_if.sv
// led_pulse_driver_if
//   Groups the game-side request signals and the LED-side status signals of
//   led_pulse_driver into one bundle.
//
//   Signal semantics (no valid/ready pair; everything is pulse or level):
//     trigger[N]  one-cycle request pulses, one per channel, active high;
//                 a trigger held high simply re-requests every cycle
//     clear       one-cycle pulse, deactivates every channel
//     blink       level; 1 = active LEDs blink, 0 = active LEDs steady on
//     led[N]      registered LED drive, active high
//     busy[N]     registered per-channel active flag (mirrors channel state)
//     any_busy    registered OR of the busy bits
//
//   Modports:
//     master  game controller / testbench side (drives requests)
//     slave   led_pulse_driver side (drives LED and status)
interface led_pulse_driver_if #(
  parameter int N = 9
);
  logic [N-1:0] trigger;
  logic         clear;
  logic         blink;
  logic [N-1:0] led;
  logic [N-1:0] busy;
  logic         any_busy;

  modport master (
    output trigger, clear, blink,
    input  led, busy, any_busy
  );

  modport slave (
    input  trigger, clear, blink,
    output led, busy, any_busy
  );
endinterface

// File: rtl/led_pulse_driver.sv
// led_pulse_driver
//   Stretches one-cycle per-hole request pulses into LED drives lasting
//   HOLD_TICKS prescaler ticks, with an optional global blink.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    led_pulse_driver_if.slave: trigger/clear/blink in,
//          led/busy/any_busy out (all outputs registered)
//
// Parameters:
//   N            number of channels
//   CLK_DIV      clk cycles per tick (>= 2)
//   HOLD_TICKS   ticks a channel stays active after its last trigger (>= 1)
//   BLINK_TICKS  ticks per blink half-period (>= 1)
//
// Each channel is a two-state FSM (IDLE/ACTIVE); busy is the registered
// state of every channel, so it doubles as the FSM debug view.
module led_pulse_driver #(
  parameter int N           = 9,
  parameter int CLK_DIV     = 100000,
  parameter int HOLD_TICKS  = 250,
  parameter int BLINK_TICKS = 50
) (
  input  logic            clk,
  input  logic            rst_n,
  led_pulse_driver_if.slave bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int RW = $clog2(HOLD_TICKS + 1);

  localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLK_MAX   = BW'(BLINK_TICKS - 1);
  localparam logic [RW-1:0] HOLD_LOAD = RW'(HOLD_TICKS);
  localparam logic [RW-1:0] REM_ONE   = RW'(1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ch_state_e;

  // ---------------------------------------------------------------------
  // Prescaler: tick is high for one cycle every CLK_DIV cycles.
  // ---------------------------------------------------------------------
  logic [PW-1:0] pre_cnt_q;
  logic          tick;

  assign tick = (pre_cnt_q == PRE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else if (tick) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_q + PW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Blink phase: free-running, independent of channel state and of the
  // blink input so every LED blinks in lockstep whenever blink is raised.
  // ---------------------------------------------------------------------
  logic [BW-1:0] blk_cnt_q;
  logic          blk_wrap;
  logic          phase_q;
  logic          phase_d;

  assign blk_wrap = tick && (blk_cnt_q == BLK_MAX);
  assign phase_d  = phase_q ^ blk_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt_q <= '0;
      phase_q   <= 1'b0;
    end else begin
      if (tick) begin
        blk_cnt_q <= blk_wrap ? '0 : blk_cnt_q + BW'(1);
      end
      phase_q <= phase_d;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel FSM: state register
  // ---------------------------------------------------------------------
  ch_state_e     state_q [N];
  ch_state_e     state_d [N];
  logic [RW-1:0] rem_q   [N];
  logic [RW-1:0] rem_d   [N];
  logic [N-1:0]  active_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= ST_IDLE;
        rem_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        rem_q[i]   <= rem_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel FSM: next state. Priority clear > trigger > tick countdown.
  // A trigger reloads the full count and swallows a coincident tick, so the
  // hold is always measured from the last trigger cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    active_d = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      rem_d[i]   = rem_q[i];
      if (bus.clear) begin
        state_d[i] = ST_IDLE;
        rem_d[i]   = '0;
      end else if (bus.trigger[i]) begin
        state_d[i] = ST_ACTIVE;
        rem_d[i]   = HOLD_LOAD;
      end else if ((state_q[i] == ST_ACTIVE) && tick) begin
        if (rem_q[i] == REM_ONE) begin
          state_d[i] = ST_IDLE;
          rem_d[i]   = '0;
        end else begin
          rem_d[i]   = rem_q[i] - RW'(1);
        end
      end
      active_d[i] = (state_d[i] == ST_ACTIVE);
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: registered from next-state values so LEDs follow triggers,
  // clears and phase toggles with no extra cycle of latency.
  // ---------------------------------------------------------------------
  logic [N-1:0] led_q;
  logic [N-1:0] busy_q;
  logic         any_busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q      <= '0;
      busy_q     <= '0;
      any_busy_q <= 1'b0;
    end else begin
      led_q      <= active_d & {N{~bus.blink | ~phase_d}};
      busy_q     <= active_d;
      any_busy_q <= |active_d;
    end
  end

  assign bus.led      = led_q;
  assign bus.busy     = busy_q;
  assign bus.any_busy = any_busy_q;

endmodule

// File: tb/tb_led_pulse_driver.sv
// tb_led_pulse_driver
//   Self-checking bench for led_pulse_driver (N=4, CLK_DIV=4, HOLD_TICKS=3,
//   BLINK_TICKS=2). The reference model works in absolute cycle numbers
//   counted from reset release: each channel is busy over an interval
//   (start, end], where end is the cycle of the HOLD_TICKS-th tick after the
//   last trigger, and the blink phase is a closed-form function of the cycle.
module tb_led_pulse_driver;

  localparam int N  = 4;
  localparam int D  = 4;   // CLK_DIV
  localparam int H  = 3;   // HOLD_TICKS
  localparam int B  = 2;   // BLINK_TICKS
  localparam int OW = 2 * N + 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  led_pulse_driver_if #(.N(N)) bus ();

  led_pulse_driver #(
    .N(N), .CLK_DIV(D), .HOLD_TICKS(H), .BLINK_TICKS(B)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [OW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            checks   = 0;
  int            failures = 0;

  // ---------------- reference model ----------------
  int start_c[N];
  int end_c[N];
  int cyc;
  bit prev_blink;

  // Cycle of the last tick of the hold for a trigger seen in cycle c.
  // Ticks happen in cycles where cycle % D == D-1.
  function automatic int expiry(input int c);
    int t;
    t = c + 1;
    while ((t % D) != (D - 1)) t++;
    return t + (H - 1) * D;
  endfunction

  // Phase visible in cycle m: number of ticks before m, halved per BLINK_TICKS.
  function automatic bit phase_at(input int m);
    return ((m / D) / B) % 2 == 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      start_c[i] = -1;
      end_c[i]   = -1;
    end
    cyc        = 0;
    prev_blink = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: drive inputs, push the expected outputs for this cycle,
  // advance the model with this cycle's inputs, move to the next cycle.
  task automatic step(input logic [N-1:0] trig, input logic clr, input logic blk);
    logic [N-1:0] e_busy;
    logic [N-1:0] e_led;
    bus.trigger = trig;
    bus.clear   = clr;
    bus.blink   = blk;
    for (int i = 0; i < N; i++) begin
      e_busy[i] = (start_c[i] < cyc) && (cyc <= end_c[i]);
      e_led[i]  = e_busy[i] && (!prev_blink || !phase_at(cyc));
    end
    exp_q.push_back({e_led, e_busy, |e_busy});
    exp_cyc_q.push_back(cyc);
    for (int i = 0; i < N; i++) begin
      if (clr) begin
        if (end_c[i] > cyc) end_c[i] = cyc;
      end else if (trig[i]) begin
        start_c[i] = cyc;
        end_c[i]   = expiry(cyc);
      end
    end
    prev_blink = blk;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic blk);
    for (int k = 0; k < n; k++) step('0, 1'b0, blk);
  endtask

  // Advance until the current cycle has the requested prescaler count.
  task automatic align(input int cnt);
    while ((cyc % D) != cnt) step('0, 1'b0, 1'b0);
  endtask

  // Hold reset for n cycles; outputs must read zero throughout.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    bus.trigger = '0;
    bus.clear   = 1'b0;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('0);
      exp_cyc_q.push_back(-1);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [OW-1:0] e;
    logic [OW-1:0] a;
    int            ec;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        a  = {bus.led, bus.busy, bus.any_busy};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs cycle=%0d {led,busy,any_busy} got=%b expected=%b",
                   ec, a, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] trig;
    logic         clr;
    logic         blk;

    rst_n       = 1'b0;
    bus.trigger = '0;
    bus.clear   = 1'b0;
    bus.blink   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(2);

    // 1: single trigger at count 0, full hold
    step(4'b0001, 1'b0, 1'b0);
    idle(14, 1'b0);

    // 2: retrigger 6 cycles later restarts the hold
    align(0);
    step(4'b0010, 1'b0, 1'b0);
    idle(5, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    idle(16, 1'b0);

    // 3: clear beats a coincident trigger while another channel is active
    step(4'b1000, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    idle(4, 1'b0);

    // 4: blink with channel 0 kept alive, then blink off
    for (int k = 0; k < 5; k++) begin
      step(4'b0001, 1'b0, 1'b1);
      idle(7, 1'b1);
    end
    idle(3, 1'b0);
    idle(12, 1'b0);

    // 5: trigger in a tick cycle, tick not counted
    align(D - 1);
    step(4'b0001, 1'b0, 1'b0);
    idle(14, 1'b0);

    // 6: reset mid-hold with all channels active
    step(4'b1111, 1'b0, 1'b0);
    idle(3, 1'b0);
    do_reset(2);
    idle(16, 1'b0);

    // Held trigger retriggers every cycle
    for (int k = 0; k < 6; k++) step(4'b0100, 1'b0, 1'b0);
    idle(14, 1'b0);

    // Randomized traffic
    blk = 1'b0;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++) trig[i] = ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) blk = ~blk;
      if ($urandom_range(0, 199) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        step(trig, clr, blk);
      end
    end
    idle(16, 1'b0);

    // Every pushed expectation must have been consumed
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain leftover=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
